// File: rtl/if_id_stage_pkg.sv
// Shared widths, FSM state encodings and bus types for the fetch front end.
package if_id_stage_pkg;

  localparam int ADDR_WIDTH       = 16;
  localparam int INST_WIDTH       = 32;
  localparam int FETCH_STATE_BITS = 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  typedef enum logic [FETCH_STATE_BITS-1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/acknowledge bus; the fetch stage is the master.
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic  req;
  addr_t addr;
  logic  ack;
  inst_t data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/if_id_stage_fetch_skid_buffer.sv
// One-entry {pc, instruction} holder that catches a response arriving while ID is stalled.
module if_id_stage_fetch_skid_buffer
  import if_id_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  logic  drain,
  input  addr_t load_pc,
  input  inst_t load_inst,
  output addr_t pc,
  output inst_t inst,
  output logic  full
);

  addr_t pc_reg;
  inst_t inst_reg;
  logic  full_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pc_reg   <= '0;
      inst_reg <= '0;
      full_reg <= 1'b0;
    end else if (load) begin
      pc_reg   <= load_pc;
      inst_reg <= load_inst;
      full_reg <= 1'b1;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign pc   = pc_reg;
  assign inst = inst_reg;
  assign full = full_reg;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: owns the PC, runs one imem request at a time and feeds the IF/ID register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter addr_t RESET_PC = '0,
  parameter addr_t ADDR_INC = addr_t'(1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  addr_t         flush_address,
  if_id_stage_if.master imem,
  output addr_t         pc_out,
  output inst_t         instruction_out,
  output logic          valid_out
);

  fetch_state_e state_reg, state_next;
  addr_t        pc_reg;
  addr_t        req_addr_reg;
  addr_t        cur_addr;
  addr_t        ifid_pc_reg;
  inst_t        ifid_inst_reg;
  logic         ifid_valid_reg;
  logic         flush_latch_reg;
  logic         in_flight;
  logic         accept;
  logic         skid_load;
  logic         skid_drain;
  logic         skid_full;
  addr_t        skid_pc;
  inst_t        skid_inst;

  // Every state except HOLD has a request on the bus.
  assign in_flight  = (state_reg != ST_HOLD);
  assign cur_addr   = (state_reg == ST_FETCH) ? pc_reg : req_addr_reg;
  assign imem.req   = in_flight && !reset;
  assign imem.addr  = reset ? '0 : cur_addr;
  assign accept     = imem.req && imem.ack && !flush &&
                      ((state_reg == ST_FETCH) || (state_reg == ST_WAIT));
  assign skid_load  = accept && stall;
  assign skid_drain = skid_full && !stall && !flush;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:   if (!imem.ack) state_next = ST_WAIT;
                  else if (stall) state_next = ST_HOLD;
      ST_WAIT:    if (imem.ack) state_next = stall ? ST_HOLD : ST_FETCH;
      ST_HOLD:    if (!stall) state_next = ST_FETCH;
      ST_DISCARD: if (imem.ack) state_next = ST_FETCH;
      default:    state_next = ST_FETCH;
    endcase
    // A redirect must still let an unacknowledged request finish on the bus.
    if (flush) state_next = (in_flight && !imem.ack) ? ST_DISCARD : ST_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_FETCH;
      pc_reg          <= RESET_PC;
      req_addr_reg    <= '0;
      ifid_pc_reg     <= '0;
      ifid_inst_reg   <= '0;
      ifid_valid_reg  <= 1'b0;
      flush_latch_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      flush_latch_reg <= flush;
      if (state_reg == ST_FETCH) req_addr_reg <= pc_reg;
      if (flush) begin
        pc_reg         <= flush_address;
        ifid_pc_reg    <= '0;
        ifid_inst_reg  <= '0;
        ifid_valid_reg <= 1'b0;
      end else begin
        if (accept) pc_reg <= cur_addr + ADDR_INC;
        if (!stall) begin
          if (accept) begin
            ifid_pc_reg    <= cur_addr;
            ifid_inst_reg  <= imem.data;
            ifid_valid_reg <= 1'b1;
          end else if (skid_full) begin
            ifid_pc_reg    <= skid_pc;
            ifid_inst_reg  <= skid_inst;
            ifid_valid_reg <= 1'b1;
          end else begin
            // Nothing new arrived: present a bubble so ID never sees a repeat.
            ifid_inst_reg  <= '0;
            ifid_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  if_id_stage_fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_pc   (cur_addr),
    .load_inst (imem.data),
    .pc        (skid_pc),
    .inst      (skid_inst),
    .full      (skid_full)
  );

  assign pc_out          = flush_latch_reg ? '0   : ifid_pc_reg;
  assign instruction_out = flush_latch_reg ? '0   : ifid_inst_reg;
  assign valid_out       = flush_latch_reg ? 1'b0 : ifid_valid_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed cycle-by-cycle vectors for the fetch stage, plus a wrap-around check on a second instance.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  reset = 1'b1;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  addr_t flush_address = '0;
  int    mem_delay = 0;
  int    mem_cnt = 0;
  int    n_cmp = 0;
  int    n_miss = 0;

  addr_t pc_out, wpc_out;
  inst_t instruction_out, winst_out;
  logic  valid_out, wvalid_out;

  if_id_stage_if mbus ();
  if_id_stage_if wbus ();

  // Memory: acknowledges after mem_delay cycles of a held request, data = addr + 0x100.
  assign mbus.ack  = mbus.req && (mem_cnt == mem_delay);
  assign mbus.data = 32'h100 + 32'(mbus.addr);
  always @(posedge clk) begin
    if (reset || !mbus.req || mbus.ack) mem_cnt <= 0;
    else                                mem_cnt <= mem_cnt + 1;
  end

  assign wbus.ack  = wbus.req;
  assign wbus.data = 32'h100 + 32'(wbus.addr);

  if_id_stage u_dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .flush_address   (flush_address),
    .imem            (mbus.master),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  if_id_stage #(.RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .stall           (1'b0),
    .flush           (1'b0),
    .flush_address   (16'h0000),
    .imem            (wbus.master),
    .pc_out          (wpc_out),
    .instruction_out (winst_out),
    .valid_out       (wvalid_out)
  );

  typedef struct {
    logic  rst;
    logic  stall;
    logic  flush;
    addr_t fa;
    int    dly;
    logic  req;
    addr_t addr;
    addr_t pc;
    inst_t inst;
    logic  valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic stl, input logic fl, input addr_t fa,
                              input int dly, input logic req, input addr_t addr, input addr_t pc,
                              input inst_t inst, input logic valid);
    vec_t v;
    v.rst = rst; v.stall = stl; v.flush = fl; v.fa = fa; v.dly = dly;
    v.req = req; v.addr = addr; v.pc = pc; v.inst = inst; v.valid = valid;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //   rst stl fl  fa       dly req addr      pc        inst          valid
    add(1, 0, 0, 16'h00, 0, 0, 16'h00, 16'h00, 32'h000, 0);  // held in reset
    add(0, 0, 0, 16'h00, 0, 1, 16'h00, 16'h00, 32'h000, 0);  // first request
    add(0, 0, 0, 16'h00, 0, 1, 16'h01, 16'h00, 32'h100, 1);
    add(0, 0, 0, 16'h00, 0, 1, 16'h02, 16'h01, 32'h101, 1);
    add(0, 0, 0, 16'h00, 0, 1, 16'h03, 16'h02, 32'h102, 1);
    add(0, 0, 0, 16'h00, 0, 1, 16'h04, 16'h03, 32'h103, 1);
    add(0, 1, 0, 16'h00, 0, 1, 16'h05, 16'h04, 32'h104, 1);  // stall, ack lands in skid
    add(0, 1, 0, 16'h00, 0, 0, 16'h05, 16'h04, 32'h104, 1);  // HOLD
    add(0, 1, 0, 16'h00, 0, 0, 16'h05, 16'h04, 32'h104, 1);
    add(0, 0, 0, 16'h00, 0, 0, 16'h05, 16'h04, 32'h104, 1);  // release, skid drains
    add(0, 0, 0, 16'h00, 0, 1, 16'h06, 16'h05, 32'h105, 1);
    add(0, 0, 0, 16'h00, 0, 1, 16'h07, 16'h06, 32'h106, 1);
    add(0, 0, 0, 16'h00, 2, 1, 16'h08, 16'h07, 32'h107, 1);  // two-wait memory
    add(0, 0, 0, 16'h00, 2, 1, 16'h08, 16'h07, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h08, 16'h07, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h09, 16'h08, 32'h108, 1);
    add(0, 0, 0, 16'h00, 2, 1, 16'h09, 16'h08, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h09, 16'h08, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h0A, 16'h09, 32'h109, 1);
    add(0, 0, 1, 16'h40, 2, 1, 16'h0A, 16'h09, 32'h000, 0);  // flush during WAIT
    add(0, 0, 0, 16'h00, 2, 1, 16'h0A, 16'h00, 32'h000, 0);  // DISCARD, late ack dropped
    add(0, 0, 0, 16'h00, 2, 1, 16'h40, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h40, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h40, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 2, 1, 16'h41, 16'h40, 32'h140, 1);
    add(0, 1, 0, 16'h00, 2, 1, 16'h41, 16'h40, 32'h000, 0);  // stall through WAIT
    add(0, 1, 0, 16'h00, 2, 1, 16'h41, 16'h40, 32'h000, 0);  // ack -> skid full
    add(0, 1, 1, 16'h80, 2, 0, 16'h41, 16'h40, 32'h000, 0);  // flush+stall in HOLD
    add(0, 0, 0, 16'h00, 0, 1, 16'h80, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 0, 1, 16'h81, 16'h80, 32'h180, 1);
    add(0, 0, 0, 16'h00, 0, 1, 16'h82, 16'h81, 32'h181, 1);
    add(0, 0, 0, 16'h00, 2, 1, 16'h83, 16'h82, 32'h182, 1);
    add(1, 0, 0, 16'h00, 2, 0, 16'h00, 16'h82, 32'h000, 0);  // reset mid-WAIT
    add(1, 0, 0, 16'h00, 2, 0, 16'h00, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 0, 1, 16'h00, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 0, 1, 16'h01, 16'h00, 32'h100, 1);
    add(0, 0, 1, 16'h20, 0, 1, 16'h02, 16'h01, 32'h101, 1);  // flush with same-cycle ack
    add(0, 0, 0, 16'h00, 0, 1, 16'h20, 16'h00, 32'h000, 0);
    add(0, 0, 0, 16'h00, 0, 1, 16'h21, 16'h20, 32'h120, 1);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      flush_address = vecs[i].fa;
      mem_delay     = vecs[i].dly;
      #1;
      $display("row %0d: req=%0b addr=%0h pc_out=%0h inst=%0h valid=%0b",
               i, mbus.req, mbus.addr, pc_out, instruction_out, valid_out);
      chk("imem_req", i, 32'(mbus.req), 32'(vecs[i].req));
      chk("imem_addr", i, 32'(mbus.addr), 32'(vecs[i].addr));
      chk("pc_out", i, 32'(pc_out), 32'(vecs[i].pc));
      chk("instruction_out", i, instruction_out, vecs[i].inst);
      chk("valid_out", i, 32'(valid_out), 32'(vecs[i].valid));
    end

    // All-ones reset PC must wrap to zero.
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; mem_delay = 0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("wrap 0: addr=%0h pc_out=%0h valid=%0b", wbus.addr, wpc_out, wvalid_out);
    chk("wrap_addr", 100, 32'(wbus.addr), 32'h0000FFFF);
    chk("wrap_valid", 100, 32'(wvalid_out), 32'h0);
    @(negedge clk);
    #1;
    $display("wrap 1: addr=%0h pc_out=%0h inst=%0h", wbus.addr, wpc_out, winst_out);
    chk("wrap_pc", 101, 32'(wpc_out), 32'h0000FFFF);
    chk("wrap_inst", 101, winst_out, 32'h000100FF);
    chk("wrap_addr", 101, 32'(wbus.addr), 32'h0);
    @(negedge clk);
    #1;
    $display("wrap 2: addr=%0h pc_out=%0h inst=%0h", wbus.addr, wpc_out, winst_out);
    chk("wrap_pc", 102, 32'(wpc_out), 32'h0);
    chk("wrap_inst", 102, winst_out, 32'h100);
    chk("wrap_valid", 102, 32'(wvalid_out), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
